// File: rtl/key_sched_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_sched_ctrl                                               |
// | Description : AES key-expansion sequencer. Invalidates keymem, then writes |
// |               the cipher key and NR expanded round keys to addr 0..NR.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module key_sched_ctrl #(
  parameter int NR     = 10,
  parameter int KEY_W  = 128,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              key_valid,
  output logic              key_ready,
  output logic [KEY_W-1:0]  exp_key_out,
  output logic [ADDR_W-1:0] exp_round,
  input  logic [KEY_W-1:0]  exp_key_in,
  output logic              km_w_en,
  output logic [ADDR_W-1:0] km_waddr,
  output logic [KEY_W-1:0]  km_wkey,
  output logic              km_reset_valid_bits,
  output logic              busy,
  output logic              done,
  output logic              key_loaded
);

  // The round index doubles as the keymem address, so NR must also fit in ADDR_W.
  if (NR < 1 || NR > 14 || NR >= (1 << ADDR_W)) begin : g_nr_check
    $error("key_sched_ctrl: NR must be in 1..14 and fit in ADDR_W bits");
  end

  localparam logic [ADDR_W-1:0] c_last_round = ADDR_W'(NR);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WR0    = 3'd2,
    S_EXPAND = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   round_q, round_d;
  logic [KEY_W-1:0]    cur_key_q, cur_key_d;
  logic                key_loaded_q, key_loaded_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      round_q      <= '0;
      cur_key_q    <= '0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      cur_key_q    <= cur_key_d;
      key_loaded_q <= key_loaded_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    round_d             = round_q;
    cur_key_d           = cur_key_q;
    key_loaded_d        = key_loaded_q;
    key_ready           = 1'b0;
    exp_key_out         = '0;
    exp_round           = '0;
    km_w_en             = 1'b0;
    km_waddr            = '0;
    km_wkey             = '0;
    km_reset_valid_bits = 1'b0;
    done                = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          cur_key_d    = key_in;
          round_d      = '0;
          key_loaded_d = 1'b0;
          state_d      = S_CLEAR;
        end
      end
      S_CLEAR: begin
        km_reset_valid_bits = 1'b1;
        state_d             = S_WR0;
      end
      S_WR0: begin
        km_w_en  = 1'b1;
        km_waddr = '0;
        km_wkey  = cur_key_q;
        round_d  = ADDR_W'(1);
        state_d  = S_EXPAND;
      end
      S_EXPAND: begin
        // Round function is combinational: its result is written this same cycle.
        exp_key_out = cur_key_q;
        exp_round   = round_q;
        km_w_en     = 1'b1;
        km_waddr    = round_q;
        km_wkey     = exp_key_in;
        cur_key_d   = exp_key_in;
        if (round_q == c_last_round) begin
          round_d = '0;
          state_d = S_DONE;
        end else begin
          round_d = round_q + ADDR_W'(1);
        end
      end
      S_DONE: begin
        done         = 1'b1;
        key_loaded_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign key_loaded = key_loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_key_sched_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_key_sched_ctrl                                            |
// | Description : Directed bench for key_sched_ctrl (AES-128 and NR=14 stub).  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_key_sched_ctrl;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready, km_w_en, km_reset_valid_bits, busy, done, key_loaded;
  logic [127:0] exp_key_out, exp_key_in, km_wkey;
  logic [3:0]   exp_round, km_waddr;

  logic [127:0] key_in14 = '0;
  logic         key_valid14 = 1'b0;
  logic         key_ready14, km_w_en14, km_rvb14, busy14, done14, key_loaded14;
  logic [127:0] exp_key_out14, exp_key_in14, km_wkey14;
  logic [3:0]   exp_round14, km_waddr14;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] model [0:15];
  logic [127:0] cap   [0:15];

  always #5 clk = ~clk;

  key_sched_ctrl #(.NR(NR), .KEY_W(128), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .exp_key_out(exp_key_out), .exp_round(exp_round),
    .exp_key_in(exp_key_in), .km_w_en(km_w_en), .km_waddr(km_waddr),
    .km_wkey(km_wkey), .km_reset_valid_bits(km_reset_valid_bits),
    .busy(busy), .done(done), .key_loaded(key_loaded)
  );

  key_sched_ctrl #(.NR(14), .KEY_W(128), .ADDR_W(4)) dut14 (
    .clk(clk), .reset(reset), .key_in(key_in14), .key_valid(key_valid14),
    .key_ready(key_ready14), .exp_key_out(exp_key_out14), .exp_round(exp_round14),
    .exp_key_in(exp_key_in14), .km_w_en(km_w_en14), .km_waddr(km_waddr14),
    .km_wkey(km_wkey14), .km_reset_valid_bits(km_rvb14),
    .busy(busy14), .done(done14), .key_loaded(key_loaded14)
  );

  // GF(2^8) arithmetic for a from-scratch AES round-key function.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] k, input logic [3:0] rnd);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc = 8'h01;
    for (int i = 1; i < int'(rnd); i++) rc = xtime(rc);
    {w0, w1, w2, w3} = k;
    t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always_comb exp_key_in = aes_round(exp_key_out, exp_round);
  always_comb exp_key_in14 = exp_key_out14 + 128'd1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts k, then checks every cycle of the schedule through the return to IDLE.
  // With hold set, key_valid stays high carrying nk so the next key is pending.
  task automatic run_sched(input logic [127:0] k, input bit hold, input logic [127:0] nk);
    model[0] = k;
    for (int i = 1; i <= NR; i++) model[i] = aes_round(model[i-1], 4'(i));
    for (int i = 0; i < 16; i++) cap[i] = 'x;
    key_in = k;
    key_valid = 1'b1;
    tick();
    if (hold) key_in = nk;
    else key_valid = 1'b0;
    for (int c = 1; c <= NR + 3; c++) begin
      chk("busy", busy, 1'b1);
      chk("key_ready", key_ready, 1'b0);
      chk("key_loaded_low", key_loaded, 1'b0);
      chk("reset_valid_bits", km_reset_valid_bits, c == 1);
      chk("w_en", km_w_en, c >= 2 && c <= NR + 2);
      chk("done", done, c == NR + 3);
      if (c >= 2 && c <= NR + 2) begin
        chk("waddr", km_waddr, c - 2);
        chk("wkey", km_wkey, model[c-2]);
        if (km_w_en) cap[km_waddr] = km_wkey;
      end else begin
        chk("waddr_idle", km_waddr, 0);
        chk("wkey_idle", km_wkey, 0);
      end
      if (c >= 3 && c <= NR + 2) begin
        chk("exp_round", exp_round, c - 2);
        chk("exp_key_out", exp_key_out, model[c-3]);
      end else begin
        chk("exp_round_idle", exp_round, 0);
        chk("exp_key_out_idle", exp_key_out, 0);
      end
      tick();
    end
    chk("ready_after", key_ready, 1'b1);
    chk("busy_after", busy, 1'b0);
    chk("key_loaded_after", key_loaded, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_waddr", km_waddr, 0);
    chk("rst_wkey", km_wkey, 0);
    reset = 1'b0;

    // Idle for ten cycles after reset.
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_ready", key_ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_w_en", km_w_en, 1'b0);
      chk("idle_rvb", km_reset_valid_bits, 1'b0);
      chk("idle_key_loaded", key_loaded, 1'b0);
    end

    // FIPS-197 key with second key pending on key_valid throughout.
    run_sched(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
    chk("fips_addr0", cap[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("fips_addr1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_addr10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Pending key accepted on the first IDLE edge.
    run_sched(128'h000102030405060708090a0b0c0d0e0f, 1'b0, '0);
    chk("key2_addr0", cap[0], 128'h000102030405060708090a0b0c0d0e0f);
    chk("key2_addr10", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    tick();

    // Async reset during EXPAND round 5.
    key_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (6) tick();
    chk("pre_reset_round", exp_round, 5);
    reset = 1'b1;
    #1;
    chk("ar_key_ready", key_ready, 1'b1);
    chk("ar_busy", busy, 1'b0);
    chk("ar_done", done, 1'b0);
    chk("ar_w_en", km_w_en, 1'b0);
    chk("ar_rvb", km_reset_valid_bits, 1'b0);
    chk("ar_waddr", km_waddr, 0);
    chk("ar_wkey", km_wkey, 0);
    chk("ar_exp_round", exp_round, 0);
    chk("ar_exp_key_out", exp_key_out, 0);
    chk("ar_key_loaded", key_loaded, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_sched(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, '0);
    chk("post_rst_addr10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // NR=14 instance with increment stub round function.
    key_in14 = 128'h0123456789abcdef_fffffffffffffffe;
    key_valid14 = 1'b1;
    tick();
    key_valid14 = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      chk("n14_w_en", km_w_en14, c >= 2 && c <= 16);
      chk("n14_rvb", km_rvb14, c == 1);
      chk("n14_done", done14, c == 17);
      if (c >= 2 && c <= 16) begin
        chk("n14_waddr", km_waddr14, c - 2);
        chk("n14_wkey", km_wkey14, 128'h0123456789abcdef_fffffffffffffffe + 128'(c - 2));
      end
      tick();
    end
    chk("n14_ready", key_ready14, 1'b1);
    chk("n14_key_loaded", key_loaded14, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
